output_buffer_ctrl: RTL
=======================

Name: output_buffer_ctrl

Overview:
- Sequencer and arbiter for the 64-row × 256-lane output buffer.
- Manages the buffer as a circular FIFO of rows. MLU result rows are the write side; DMA drain commands are the read side.
- Only one buffer op (one index, one of write/read) is possible per cycle, so the block round-robins between writer and drainer.
- Drives the buffer's idx/write_en/read_en and tracks occupancy, pointers and drain progress.

Parameters:
DEPTH, 64, buffer rows
IDX_W, 6, row index width (log2 DEPTH)
CNT_W, 7, occupancy/length width (holds 0..DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
wr_req  in  1  MLU has a result row on the buffer data input this cycle
wr_ack  out  1  row written this cycle (combinational)
rd_cmd_valid  in  1  DMA drain command valid
rd_cmd_len  in  CNT_W  rows to drain, 0..64
rd_cmd_ready  out  1  command accepted when valid&&ready
rd_data_valid  out  1  buffer output holds a drained row (registered)
rd_done  out  1  one-cycle pulse, drain command complete (registered)
buf_idx  out  IDX_W  row index to buffer (combinational)
buf_write_en  out  1  buffer write enable (combinational)
buf_read_en  out  1  buffer read enable (combinational)
count  out  CNT_W  current occupancy
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (rst low, async) sets:
  - wr_ptr=0, rd_ptr=0, count=0, remaining=0
  - state=IDLE, rr_last=READ (so write wins first contention)
  - rd_data_valid=0, rd_done=0
  - Buffer contents are not cleared; with count=0 they are unreachable.
- Eligibility:
  - write eligible = wr_req && !full
  - read eligible = state==DRAIN && remaining!=0 && !empty
- Grant:
  - Only one eligible side: that side is granted.
  - Both eligible: grant the side not granted at the last contention; rr_last updates only on contention cycles.
- Buffer drive:
  - Write grant: buf_write_en=1, buf_idx=wr_ptr, wr_ack=1.
  - Read grant: buf_read_en=1, buf_idx=rd_ptr.
  - Otherwise: both enables 0, buf_idx=rd_ptr (don't-care).
  - write_en and read_en are never both 1.
- Pointers: wr_ptr/rd_ptr increment by 1 on their grant and wrap 63→0 naturally.
- Occupancy: count +1 on write grant, −1 on read grant; at most one per cycle.
- Read latency: the buffer registers its output at the posedge, so rd_data_valid is the read grant delayed by one cycle.
- FSM:
  - IDLE: rd_cmd_ready=1. On accept:
    - len!=0: remaining=len, go to DRAIN.
    - len==0: go to DONE; no reads issued.
  - DRAIN: rd_cmd_ready=0. Each read grant does remaining−1. The grant that brings remaining to 0 moves to DONE.
  - DONE: rd_done=1 for exactly one cycle, coincident with the last rd_data_valid. Then go to IDLE.
- Boundary conditions:
  - len > count: drain stalls on empty (no read_en), waits for writes, completes after exactly len reads.
  - Full: wr_ack=0 and no write, even if no drain is active. The writer holds wr_req and data until acked.
  - Write into a slot freed by a read in the same cycle cannot happen (single grant per cycle).
  - Reset mid-drain: abort, no rd_done, pointers cleared.
  - New commands are not accepted in DRAIN or DONE.

Decomposition:
- Package obuf_pkg: DEPTH, IDX_W, CNT_W; state enum {IDLE, DRAIN, DONE}; grant enum {GNT_NONE, GNT_WR, GNT_RD}.
- Sub-module obuf_rr_arb: 2-requester round-robin with rr_last flop. Inputs: two eligibles, clk, rst. Output: grant.

Test Plan:
- Reset, then wr_req held 3 cycles → buf_write_en with buf_idx 0,1,2; wr_ack=1 each cycle; count=3; empty=0.
- 64 writes → full=1, count=64; 65th wr_req → wr_ack=0, buf_write_en=0 until a read frees a slot.
- count=4, command len=4, no writes:
  - read_en with idx 0..3 on cycles T..T+3
  - rd_data_valid on T+1..T+4
  - rd_done only at T+4, then rd_cmd_ready=1 at T+5
- Drain len=8 with wr_req held, count=8 at start → grants alternate W,R,W,R starting with W; count stays 8–9; rd_done after the 8th read.
- Wrap:
  - write 62, drain 62, write 4 → write idx 62,63,0,1
  - drain 4 → read idx 62,63,0,1
  - count=0, empty=1
- Edge commands:
  - len=10 with count=3 → 3 reads, then stall with no read_en; 7 writes resume reads; rd_done after the 10th.
  - len=0 → rd_done one cycle after accept, no read_en.
  - rst low mid-drain → all outputs at reset values, no rd_done.

Source files
------------

// File: rtl/obuf_pkg.sv
// Shared sizes and state/grant encodings for the output buffer controller.
package obuf_pkg;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_e;

endpackage

// File: rtl/obuf_rr_arb.sv
// Two-requester round-robin arbiter (writer vs drainer) for the single buffer port.
module obuf_rr_arb
  import obuf_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_elig,
  input  logic   rd_elig,
  output grant_e grant_c
);

  grant_e rr_last;

  // Contention goes to whichever side lost the previous contention.
  always_comb begin
    grant_c = GNT_NONE;
    if (wr_elig && rd_elig) begin
      grant_c = (rr_last == GNT_RD) ? GNT_WR : GNT_RD;
    end else if (wr_elig) begin
      grant_c = GNT_WR;
    end else if (rd_elig) begin
      grant_c = GNT_RD;
    end
  end

  // History only moves on contention so an idle side never loses its turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last <= GNT_RD;
    end else if (wr_elig && rd_elig) begin
      rr_last <= grant_c;
    end
  end

endmodule

// File: rtl/output_buffer_ctrl.sv
// Circular-FIFO sequencer for the output buffer: MLU rows in, DMA drain commands out,
// one buffer operation per cycle.
module output_buffer_ctrl
  import obuf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  output logic             wr_ack,
  input  logic             rd_cmd_valid,
  input  logic [CNT_W-1:0] rd_cmd_len,
  output logic             rd_cmd_ready,
  output logic             rd_data_valid,
  output logic             rd_done,
  output logic [IDX_W-1:0] buf_idx,
  output logic             buf_write_en,
  output logic             buf_read_en,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  state_e           state;
  state_e           state_next;
  grant_e           grant;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic [CNT_W-1:0] remaining;
  logic             wr_elig;
  logic             rd_elig;
  logic             cmd_accept;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign wr_elig    = wr_req && !full;
  assign rd_elig    = (state == DRAIN) && (remaining != '0) && !empty;
  assign rd_cmd_ready = (state == IDLE);
  assign cmd_accept = rd_cmd_valid && rd_cmd_ready;

  obuf_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .wr_elig (wr_elig),
    .rd_elig (rd_elig),
    .grant_c (grant)
  );

  assign buf_write_en = (grant == GNT_WR);
  assign buf_read_en  = (grant == GNT_RD);
  assign wr_ack       = buf_write_en;
  assign buf_idx      = buf_write_en ? wr_ptr : rd_ptr;

  // Drain command sequencing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          state_next = (rd_cmd_len == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (buf_read_en && (remaining == CNT_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, occupancy and drain progress; read data lands one cycle after the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      remaining     <= '0;
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
    end else begin
      rd_data_valid <= buf_read_en;
      rd_done       <= (state_next == DONE);
      if (buf_write_en) begin
        wr_ptr <= wr_ptr + IDX_W'(1);
        count  <= count + CNT_W'(1);
      end else if (buf_read_en) begin
        rd_ptr <= rd_ptr + IDX_W'(1);
        count  <= count - CNT_W'(1);
      end
      if (cmd_accept) begin
        remaining <= rd_cmd_len;
      end else if (buf_read_en) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule
